// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with registered sync and blanking.
// All outputs are loaded from next-state counters so they track row/col exactly.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          HSync,
    output logic          VSync,
    output logic          output_en,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    // One extra bit so a window ending exactly at 2^CW stays representable
    localparam logic [CW:0] H_VIS = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] V_VIS = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] HS_LO = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_HI = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] VS_LO = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_HI = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic          h_wrap;
    logic          v_wrap;
    logic [CW-1:0] row_nxt;
    logic [CW-1:0] col_nxt;

    function automatic logic in_win(
        input logic [CW-1:0] v,
        input logic [CW:0]   lo,
        input logic [CW:0]   hi
    );
        return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
    endfunction

    always_comb begin
        h_wrap  = (row == H_LAST);
        v_wrap  = (col == V_LAST);
        row_nxt = h_wrap ? '0 : row + ONE;
        col_nxt = col;
        if (h_wrap) begin
            col_nxt = v_wrap ? '0 : col + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row         <= '0;
            col         <= '0;
            HSync       <= ~HS_POL;
            VSync       <= ~VS_POL;
            output_en   <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                row         <= row_nxt;
                col         <= col_nxt;
                HSync       <= in_win(row_nxt, HS_LO, HS_HI) ?
                               HS_POL : ~HS_POL;
                VSync       <= in_win(col_nxt, VS_LO, VS_HI) ?
                               VS_POL : ~VS_POL;
                output_en   <= ({1'b0, row_nxt} < H_VIS) &&
                               ({1'b0, col_nxt} < V_VIS);
                line_start  <= h_wrap;
                frame_start <= h_wrap && v_wrap;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets checked every cycle
// against a step-count model of the raster.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [31:0] row;
        logic [31:0] col;
        logic        hs;
        logic        vs;
        logic        oe;
        logic        ls;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b0;

    logic [9:0] d_row, d_col, v_row, v_col;
    logic [3:0] s_row, s_col;
    logic d_hs, d_vs, d_oe, d_ls, d_fs;
    logic v_hs, v_vs, v_oe, v_ls, v_fs;
    logic s_hs, s_vs, s_oe, s_ls, s_fs;

    int checks = 0;
    int errors = 0;

    // model state: pixel steps since reset, and whether last edge stepped
    longint n = 0;
    bit     st = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .row(d_row), .col(d_col), .HSync(d_hs), .VSync(d_vs),
        .output_en(d_oe), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1)
    ) dut_v (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .row(v_row), .col(v_col), .HSync(v_hs), .VSync(v_vs),
        .output_en(v_oe), .line_start(v_ls), .frame_start(v_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .CW(4)
    ) dut_s (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .row(s_row), .col(s_col), .HSync(s_hs), .VSync(s_vs),
        .output_en(s_oe), .line_start(s_ls), .frame_start(s_fs)
    );

    always @(posedge clk) begin
        if (reset) begin
            n  = 0;
            st = 1'b0;
        end else if (pix_en) begin
            n  = n + 1;
            st = 1'b1;
        end else begin
            st = 1'b0;
        end
    end

    function automatic obs_t model(
        input int ha, input int hf, input int hw, input int hb,
        input int va, input int vf, input int vw, input int vb,
        input bit hp, input bit vp
    );
        obs_t   e;
        longint ht = ha + hf + hw + hb;
        longint vt = va + vf + vw + vb;
        longint r = n % ht;
        longint c = (n / ht) % vt;
        e.row = 32'(r);
        e.col = 32'(c);
        e.hs  = (r >= ha + hf && r < ha + hf + hw) ? hp : !hp;
        e.vs  = (c >= va + vf && c < va + vf + vw) ? vp : !vp;
        e.oe  = (r < ha) && (c < va);
        e.ls  = st && (r == 0);
        e.fs  = st && ((n % (ht * vt)) == 0);
        return e;
    endfunction

    function automatic obs_t get_exp(input int k);
        case (k)
            0:       return model(640, 16, 96, 48, 480, 10, 2, 33, 0, 0);
            1:       return model(8, 2, 3, 1, 480, 10, 2, 33, 0, 0);
            default: return model(8, 2, 3, 1, 4, 1, 1, 1, 1, 0);
        endcase
    endfunction

    function automatic obs_t get_obs(input int k);
        obs_t o;
        case (k)
            0: begin
                o.row = 32'(d_row); o.col = 32'(d_col);
                o.hs = d_hs; o.vs = d_vs; o.oe = d_oe;
                o.ls = d_ls; o.fs = d_fs;
            end
            1: begin
                o.row = 32'(v_row); o.col = 32'(v_col);
                o.hs = v_hs; o.vs = v_vs; o.oe = v_oe;
                o.ls = v_ls; o.fs = v_fs;
            end
            default: begin
                o.row = 32'(s_row); o.col = 32'(s_col);
                o.hs = s_hs; o.vs = s_vs; o.oe = s_oe;
                o.ls = s_ls; o.fs = s_fs;
            end
        endcase
        return o;
    endfunction

    task automatic tick(input bit pe, input bit rst);
        pix_en = pe;
        reset  = rst;
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t o, e;
        for (int i = 0; i < 3; i++) begin
            tick(1'($urandom), 1'b1);
            for (int k = 0; k < 3; k++) begin
                o = get_obs(k); e = get_exp(k); checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL reset dut%0d n=%0d got %h want %h",
                             k, n, o, e);
                end
            end
        end
        checks++;
        if ({d_row, d_col, d_hs, d_vs, d_oe, d_ls, d_fs} !==
            {10'd0, 10'd0, 5'b11100}) begin
            errors++;
            $display("FAIL reset_vals got %0d,%0d %b%b%b%b%b want 0,0 11100",
                     d_row, d_col, d_hs, d_vs, d_oe, d_ls, d_fs);
        end
    endtask

    task automatic test_row_sweep();
        obs_t o, e;
        int hs_low = 0, oe_low = 0, ls_cnt = 0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 810; i++) begin
            tick(1'b1, 1'b0);
            for (int k = 0; k < 3; k++) begin
                o = get_obs(k); e = get_exp(k); checks++;
                if (o !== e) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL row_sweep dut%0d n=%0d got %h want %h",
                                 k, n, o, e);
                end
            end
            if (i < 800) begin
                if (d_hs == 1'b0) hs_low++;
                if (d_oe == 1'b0) oe_low++;
                if (d_ls == 1'b1) ls_cnt++;
            end
        end
        checks++;
        if (hs_low != 96) begin
            errors++;
            $display("FAIL hs_low_width got %0d want 96", hs_low);
        end
        checks++;
        if (oe_low != 160) begin
            errors++;
            $display("FAIL oe_blank_width got %0d want 160", oe_low);
        end
        checks++;
        if (ls_cnt != 1) begin
            errors++;
            $display("FAIL line_start_count got %0d want 1", ls_cnt);
        end
    endtask

    task automatic test_full_frame();
        obs_t o, e;
        int v_fs_n = 0, v_ls_n = 0, v_vs_low = 0;
        int s_fs_n = 0, s_hs_hi = 0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 7350; i++) begin
            tick(1'b1, 1'b0);
            for (int k = 0; k < 3; k++) begin
                o = get_obs(k); e = get_exp(k); checks++;
                if (o !== e) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL frame dut%0d n=%0d got %h want %h",
                                 k, n, o, e);
                end
            end
            if (v_fs) v_fs_n++;
            if (v_ls) v_ls_n++;
            if (!v_vs) v_vs_low++;
            if (s_fs) s_fs_n++;
            if (s_hs) s_hs_hi++;
        end
        checks++;
        if (v_fs_n != 1) begin
            errors++;
            $display("FAIL frame_start_count got %0d want 1", v_fs_n);
        end
        checks++;
        if (v_ls_n != 525) begin
            errors++;
            $display("FAIL line_start_frame got %0d want 525", v_ls_n);
        end
        checks++;
        if (v_vs_low != 28) begin
            errors++;
            $display("FAIL vsync_low_width got %0d want 28", v_vs_low);
        end
        checks++;
        if (s_fs_n != 75) begin
            errors++;
            $display("FAIL small_frame_count got %0d want 75", s_fs_n);
        end
        checks++;
        if (s_hs_hi != 1575) begin
            errors++;
            $display("FAIL small_hs_high got %0d want 1575", s_hs_hi);
        end
    endtask

    task automatic test_pix_en_wrap();
        obs_t o, e;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] ls_seq;
        logic [39:0] row_seq;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 799; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(pat[i], 1'b0);
            ls_seq[3-i] = d_ls;
            row_seq[(3-i)*10 +: 10] = d_row;
            for (int k = 0; k < 3; k++) begin
                o = get_obs(k); e = get_exp(k); checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL pix_wrap dut%0d n=%0d got %h want %h",
                             k, n, o, e);
                end
            end
        end
        checks++;
        if (ls_seq !== 4'b1000) begin
            errors++;
            $display("FAIL ls_pulse got %b want 1000", ls_seq);
        end
        checks++;
        if (row_seq !== {10'd0, 10'd0, 10'd0, 10'd1}) begin
            errors++;
            $display("FAIL hold_rows got %h want %h", row_seq,
                     {10'd0, 10'd0, 10'd0, 10'd1});
        end
        for (int i = 0; i < 1500; i++) begin
            tick(1'($urandom), 1'b0);
            for (int k = 0; k < 3; k++) begin
                o = get_obs(k); e = get_exp(k); checks++;
                if (o !== e) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL pix_rand dut%0d n=%0d got %h want %h",
                                 k, n, o, e);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        obs_t o, e;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 700; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        checks++;
        if ({d_row, d_col, d_hs, d_vs, d_oe, d_ls, d_fs} !==
            {10'd0, 10'd0, 5'b11100}) begin
            errors++;
            $display("FAIL reset_row700 got %0d,%0d %b%b%b%b%b want 0,0 11100",
                     d_row, d_col, d_hs, d_vs, d_oe, d_ls, d_fs);
        end
        for (int i = 0; i < 491 * 14 + 5; i++) tick(1'b1, 1'b0);
        checks++;
        if ({v_col, v_vs} !== {10'd491, 1'b0}) begin
            errors++;
            $display("FAIL at_col491 got col=%0d vs=%b want 491 0",
                     v_col, v_vs);
        end
        tick(1'b1, 1'b1);
        checks++;
        if ({v_row, v_col, v_hs, v_vs, v_oe, v_ls, v_fs} !==
            {10'd0, 10'd0, 5'b11100}) begin
            errors++;
            $display("FAIL reset_col491 got %0d,%0d %b%b%b%b%b want 0,0 11100",
                     v_row, v_col, v_hs, v_vs, v_oe, v_ls, v_fs);
        end
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        checks++;
        if ({d_row, d_col, d_ls} !== {10'd1, 10'd0, 1'b0}) begin
            errors++;
            $display("FAIL resume got %0d,%0d ls=%b want 1,0 ls=0",
                     d_row, d_col, d_ls);
        end
        for (int i = 0; i < 500; i++) begin
            tick(1'($urandom), ($urandom_range(0, 49) == 0));
            for (int k = 0; k < 3; k++) begin
                o = get_obs(k); e = get_exp(k); checks++;
                if (o !== e) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL rand_reset dut%0d n=%0d got %h want %h",
                                 k, n, o, e);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_row_sweep();
        test_full_frame();
        test_pix_en_wrap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
